// File: rtl/vector_mem_ctrl_if.sv
// Command, memory and response signals of the vector memory sequencer.
// The controller takes the slave view; the environment takes the master view.
interface vector_mem_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int WORD_W = 32,
  parameter int LANES  = 16
);
  localparam int VEC_W = WORD_W * LANES;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [VEC_W-1:0]  cmd_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [VEC_W-1:0]  mem_wdata;
  logic              mem_we;
  logic [VEC_W-1:0]  mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [VEC_W-1:0]  rsp_rdata;
  logic              rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, mem_rdata, rsp_ready,
    output cmd_ready, mem_addr, mem_wdata, mem_we, rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, mem_rdata, rsp_ready,
    input  cmd_ready, mem_addr, mem_wdata, mem_we, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/vector_mem_ctrl.sv
// Single-outstanding vector load/store sequencer in front of a 512x32 memory
// with combinational read; one command per IDLE -> ACCESS -> RESP round trip.
module vector_mem_ctrl #(
  parameter int ADDR_W = 9,
  parameter int WORD_W = 32,
  parameter int LANES  = 16
) (
  input logic              clk,
  input logic              rst_n,
  vector_mem_ctrl_if.slave bus
);
  localparam int VEC_W = WORD_W * LANES;
  // Highest legal base address, widened so the compare cannot wrap.
  localparam logic [ADDR_W:0] MAX_BASE = (ADDR_W + 1)'((1 << ADDR_W) - LANES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [VEC_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [VEC_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              addr_ok;

  assign addr_ok = {1'b0, bus.cmd_addr} <= MAX_BASE;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    op_d        = op_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          op_d        = bus.cmd_op;
          if (addr_ok) begin
            state_d    = ACCESS;
            mem_addr_d = bus.cmd_addr;
            mem_we_d   = bus.cmd_op;
            if (bus.cmd_op) mem_wdata_d = bus.cmd_wdata;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = op_q ? '0 : bus.mem_rdata;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      op_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      op_q        <= op_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
